// File: rtl/seg7_pkg.sv
// Shared segment patterns, sizes and FSM states for the 4-digit 7-segment scan path.
// Patterns are active-low, bit order gfedcba (bit0 = segment a).
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_W      = 14;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ACCUM   = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low segment pattern to a BCD digit plus an illegal-pattern flag.
// A blanked digit (leading-zero suppression) reads back as 0 without error.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       err
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        digit = 4'd0;
        err   = 1'b0;
        case (pattern)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = 4'd0;
            default:   err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the 4-digit value shown by a multiplexed 7-segment driver from its segment/anode lines.
// Optional SEG7_GLITCH_FILTER_EN: require STABLE_CYCLES of unchanged lines before sampling a digit.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            controls,
    input  logic [3:0]            seg_ctrl,
    output logic [NUM_W-1:0]      num,
    output logic                  num_valid,
    output logic                  decode_err,
    output logic [NUM_DIGITS-1:0] digit_mask
);

    if (STABLE_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_param_check
        $error("seg7_scan_capture: need STABLE_CYCLES >= 1 and 2**TO_W > TIMEOUT_CYCLES");
    end

    state_t          state, state_next;
    logic [10:0]     pair, pair_q;
    logic            pair_changed;
    logic            anode_valid;
    logic [1:0]      anode_idx;
    logic [3:0]      dec_digit;
    logic            dec_err;
    logic            sample;

    logic [3:0]            digits      [NUM_DIGITS];
    logic [3:0]            digits_next [NUM_DIGITS];
    logic [3:0]            shadow      [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] errs, errs_next, shadow_err, mask_next;
    logic [TO_W-1:0]       to_cnt;
    logic [NUM_W-1:0]      acc;
    logic [1:0]            idx;
    logic                  load_frame, acc_step, emit_ok, emit_err;

    assign pair         = {controls, seg_ctrl};
    assign pair_changed = (pair != pair_q);

    seg7_pattern_decode u_decode (
        .pattern (controls),
        .digit   (dec_digit),
        .err     (dec_err)
    );

    always_comb begin
        anode_valid = 1'b0;
        anode_idx   = 2'd0;
        case (seg_ctrl)
            4'b1110: begin anode_valid = 1'b1; anode_idx = 2'd0; end
            4'b1101: begin anode_valid = 1'b1; anode_idx = 2'd1; end
            4'b1011: begin anode_valid = 1'b1; anode_idx = 2'd2; end
            4'b0111: begin anode_valid = 1'b1; anode_idx = 2'd3; end
            default: ;
        endcase
    end

`ifdef SEG7_GLITCH_FILTER_EN
    localparam int              ST_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(STABLE_CYCLES - 1);

    logic [ST_W-1:0] stab_cnt, stab_next;
    logic            fired;

    // Counter saturates at ST_MAX; 'fired' keeps a long dwell from sampling twice.
    always_comb begin
        if (!anode_valid || pair_changed)
            stab_next = '0;
        else if (stab_cnt == ST_MAX)
            stab_next = stab_cnt;
        else
            stab_next = stab_cnt + 1'b1;
        sample = anode_valid && (stab_next == ST_MAX) && (pair_changed || !fired);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stab_cnt <= '0;
            fired    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
            stab_cnt <= stab_next;
            fired    <= sample | (fired & ~pair_changed);
        end
    end
`else
    assign sample = anode_valid && pair_changed;
`endif

    always_comb begin
        digits_next = digits;
        errs_next   = errs;
        mask_next   = digit_mask;
        if (sample) begin
            digits_next[anode_idx] = dec_digit;
            errs_next[anode_idx]   = dec_err;
            mask_next[anode_idx]   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= COLLECT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (mask_next == '1) state_next = ACCUM;
            ACCUM:   if (idx == 2'd0)     state_next = EMIT;
            EMIT:                         state_next = COLLECT;
            default:                      state_next = COLLECT;
        endcase
    end

    always_comb begin
        load_frame = (state == COLLECT) && (mask_next == '1);
        acc_step   = (state == ACCUM);
        emit_ok    = (state == EMIT) && (shadow_err == '0);
        emit_err   = (state == EMIT) && (shadow_err != '0);
    end

    // Capture registers are only four nibbles, so they take the reset like any other flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pair_q     <= '0;
            digits     <= '{default: '0};
            errs       <= '0;
            digit_mask <= '0;
            to_cnt     <= '0;
        end else begin
            pair_q <= pair;
            digits <= digits_next;
            errs   <= errs_next;
            if (load_frame) begin
                digit_mask <= '0;
                to_cnt     <= '0;
            end else if (sample) begin
                digit_mask <= mask_next;
                to_cnt     <= '0;
            end else if (state == COLLECT && digit_mask != '0) begin
                if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    digit_mask <= '0;
                    to_cnt     <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    // Horner evaluation, thousands first: acc = acc*10 + digit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow     <= '{default: '0};
            shadow_err <= '0;
            acc        <= '0;
            idx        <= '0;
            num        <= '0;
            num_valid  <= 1'b0;
            decode_err <= 1'b0;
        end else begin
            if (load_frame) begin
                shadow     <= digits_next;
                shadow_err <= errs_next;
                acc        <= '0;
                idx        <= 2'd3;
            end else if (acc_step) begin
                acc <= (acc << 3) + (acc << 1) + {{(NUM_W-4){1'b0}}, shadow[idx]};
                idx <= idx - 1'b1;
            end
            num_valid  <= emit_ok;
            decode_err <= emit_err;
            if (emit_ok) num <= acc;
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed self-checking bench for seg7_scan_capture; follows SEG7_GLITCH_FILTER_EN where behaviour differs.
// Inputs change just after the falling edge, outputs are checked on falling edges.
module tb_seg7_scan_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  controls;
    logic [3:0]  seg_ctrl;
    logic [13:0] num;
    logic        num_valid;
    logic        decode_err;
    logic [3:0]  digit_mask;

    int tests = 0;
    int fails = 0;
    int nv_cnt = 0;
    int err_cnt = 0;
    int nv_base, err_base, lat;
    bit found;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b0110110;
    logic [6:0] p [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

`ifdef SEG7_GLITCH_FILTER_EN
    localparam int          EXP_LAT    = 7;
    localparam logic [3:0]  GLITCH_MSK = 4'b0001;
`else
    localparam int          EXP_LAT    = 6;
    localparam logic [3:0]  GLITCH_MSK = 4'b0101;
`endif

    seg7_scan_capture dut (
        .clock      (clock),
        .reset      (reset),
        .controls   (controls),
        .seg_ctrl   (seg_ctrl),
        .num        (num),
        .num_valid  (num_valid),
        .decode_err (decode_err),
        .digit_mask (digit_mask)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (num_valid)  nv_cnt++;
        if (decode_err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic dwell(input logic [6:0] seg, input int pos, input int n);
        controls = seg;
        seg_ctrl = ~(4'b0001 << pos);
        idle(n);
    endtask

    task automatic blank(input int n);
        controls = BLANK;
        seg_ctrl = 4'b1111;
        idle(n);
    endtask

    task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
        dwell(s0, 0, 4);
        dwell(s1, 1, 4);
        dwell(s2, 2, 4);
        dwell(s3, 3, 4);
        blank(10);
    endtask

    initial begin
        reset    = 1'b0;
        controls = BLANK;
        seg_ctrl = 4'b1111;
        idle(3);
        check("reset_num", num, 0);
        check("reset_num_valid", num_valid, 0);
        check("reset_decode_err", decode_err, 0);
        check("reset_digit_mask", digit_mask, 0);
        reset = 1'b1;
        idle(2);

        // 0232 with explicit thousands zero, plus latency from the fourth sample
        nv_base = nv_cnt; err_base = err_cnt;
        dwell(p[2], 0, 4);
        dwell(p[3], 1, 4);
        dwell(p[2], 2, 4);
        check("t1_mask_three", digit_mask, 4'b0111);
        controls = p[0];
        seg_ctrl = 4'b0111;
        lat = 0; found = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (num_valid && !found) begin lat = i; found = 1; end
        end
        check("t1_latency", lat, EXP_LAT);
        blank(4);
        check("t1_num", num, 232);
        check("t1_pulses", nv_cnt - nv_base, 1);
        check("t1_no_err", err_cnt - err_base, 0);
        check("t1_mask_cleared", digit_mask, 0);

        nv_base = nv_cnt;
        scan(p[9], p[9], p[9], p[9]);
        check("t2_num_9999", num, 9999);
        check("t2_pulse_9999", nv_cnt - nv_base, 1);

        // Illegal tens pattern: error pulse, value held
        nv_base = nv_cnt; err_base = err_cnt;
        scan(p[1], p[2], BAD, p[4]);
        check("t3_err_pulse", err_cnt - err_base, 1);
        check("t3_no_valid", nv_cnt - nv_base, 0);
        check("t3_num_held", num, 9999);

        nv_base = nv_cnt;
        scan(BLANK, BLANK, BLANK, p[0]);
        check("t2_num_blank0", num, 0);
        check("t2_pulse_blank0", nv_cnt - nv_base, 1);

        // Partial frame abandoned by timeout
        nv_base = nv_cnt; err_base = err_cnt;
        dwell(p[2], 0, 4);
        dwell(p[3], 1, 4);
        dwell(p[4], 2, 4);
        blank(1);
        check("t5_mask_partial", digit_mask, 4'b0111);
        idle(4000);
        check("t5_mask_before_to", digit_mask, 4'b0111);
        idle(200);
        check("t5_mask_after_to", digit_mask, 0);
        check("t5_no_pulses", (nv_cnt - nv_base) + (err_cnt - err_base), 0);

        // 7432 with a one-cycle hundreds-anode glitch after the ones dwell
        nv_base = nv_cnt;
        dwell(p[2], 0, 4);
        dwell(p[2], 2, 1);
        check("t4_glitch_mask", digit_mask, GLITCH_MSK);
        dwell(p[3], 1, 4);
        dwell(p[4], 2, 4);
        dwell(p[7], 3, 4);
        blank(10);
        check("t4_num_7432", num, 7432);
        check("t4_pulse_7432", nv_cnt - nv_base, 1);

        // Reset during ACCUM of 4564
        nv_base = nv_cnt;
        dwell(p[4], 0, 4);
        dwell(p[6], 1, 4);
        dwell(p[5], 2, 4);
        dwell(p[4], 3, 3);
        reset = 1'b0;
        #1;
        check("t6_reset_num", num, 0);
        check("t6_reset_valid", num_valid, 0);
        check("t6_reset_mask", digit_mask, 0);
        blank(3);
        reset = 1'b1;
        blank(10);
        check("t6_no_valid", nv_cnt - nv_base, 0);
        check("t6_num_zero", num, 0);

        nv_base = nv_cnt;
        scan(BLANK, p[6], p[0], p[9]);
        check("t6_num_609", num, 609);
        check("t6_pulse_609", nv_cnt - nv_base, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
Receive-side counterpart of the 4-digit multiplexed 7-segment driver. Watches the driver's segment and anode lines and recovers each digit from its segment pattern. Once all four digits have been captured, it rebuilds the 14-bit decimal value. Used as a loop-back checker and as a bus-side readback of the display value.

Parameters:
STABLE_CYCLES, 2, cycles an anode/segment pair must hold unchanged before it is sampled (used only with SEG7_GLITCH_FILTER_EN).
TIMEOUT_CYCLES, 4096, idle cycles without a new digit sample before a partial frame is discarded.
TO_W, 13, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
controls  input  7  segment lines, active-low; bit0=a … bit6=g.
seg_ctrl  input  4  anode lines, active-low one-cold; bit0=ones digit, bit3=thousands digit.
num  output  14  last successfully reconstructed value, 0..9999.
num_valid  output  1  one-cycle pulse when num updates.
decode_err  output  1  one-cycle pulse when a completed frame held an illegal segment pattern.
digit_mask  output  4  digits captured so far in the current frame.

Behaviour:
- Reset (asynchronous assert, synchronous release): num=0, num_valid=0, decode_err=0, digit_mask=0, state=COLLECT, digit registers=0, error flags=0, counters=0.
- Anode is valid only when exactly one seg_ctrl bit is 0. All-ones (blanked) and multiple-low anodes are ignored and clear the stability counter.
- Segment decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 1111111 (leading-zero blank) decodes as 0.
  - Any other pattern decodes as 0 and sets that digit's err flag.
- Sample event:
  - The stability counter reaches STABLE_CYCLES-1 with the anode valid and {controls,seg_ctrl} unchanged.
  - Fires exactly once per dwell; it re-arms only when {controls,seg_ctrl} changes.
  - On a sample: write the digit register and err flag at the anode index, set that digit_mask bit, clear the timeout counter.
  - Re-sampling a digit already in the mask overwrites it.
- FSM:
  - COLLECT: sample as above. When digit_mask becomes 4'b1111, in the same edge snapshot the digits and err flags into a shadow, clear digit_mask, clear acc, set i=3, and go to ACCUM.
  - ACCUM: 4 cycles of Horner, acc = acc*10 + shadow[i] (acc 14-bit; *10 as (acc<<3)+(acc<<1); max 9999, no overflow). i decrements each cycle; after i=0 go to EMIT. Sampling into digit_mask continues during ACCUM.
  - EMIT, one cycle, then COLLECT:
    - If any shadow err flag is set: pulse decode_err; num holds.
    - Otherwise: num<=acc and pulse num_valid.
- Latency: num_valid is asserted 5 cycles after the edge on which the fourth digit is sampled.
- Timeout: the counter increments every cycle in COLLECT while digit_mask≠0. On reaching TIMEOUT_CYCLES, digit_mask clears and the counter clears. num is unaffected.
- If the fourth digit's sample and the timeout coincide, the sample wins.
- Reset asserted mid-ACCUM/EMIT aborts with no pulse; all outputs go to their reset values.

Optional Feature:
SEG7_GLITCH_FILTER_EN
- Defined: the stability filter above applies with STABLE_CYCLES.
- Undefined: the stability counter is removed. A sample fires on the first cycle a valid anode differs from the previous cycle's {controls,seg_ctrl}. STABLE_CYCLES is ignored.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK pattern constants, shared with the driver.
  - NUM_DIGITS=4, NUM_W=14.
  - The state enum {COLLECT, ACCUM, EMIT}.
- One natural sub-module, seg7_pattern_decode: combinational 7-bit pattern to {digit[3:0], err}.

Test Plan:
- Reset, then scan digits 0,2,3,2 (ones=2, tens=3, hundreds=2, thousands=0 as pattern 1000000), each dwell 4 cycles → one num_valid pulse, num=232, decode_err=0.
- Scan 9999, then 0 with thousands/hundreds/tens blanked (1111111) → num=9999 then num=0, two num_valid pulses.
- Tens digit driven 0110110, others legal → decode_err pulses once, num_valid stays 0, num retains the previous value.
- Filter defined, STABLE_CYCLES=2: a 1-cycle anode glitch on bit2 between dwells → no sample, digit_mask unchanged; the full scan still yields the correct num.
- Capture only 3 digits, then idle for TIMEOUT_CYCLES → digit_mask returns to 0, no pulses. A fresh full scan of 7432 → num=7432.
- Assert reset during ACCUM of a 4564 frame → no num_valid, num=0. After release, a fresh scan of 609 → num=609.
